// File: rtl/atm_bank_arbiter.sv
// Round-robin arbiter that runs read-check-write balance/withdraw/transfer operations on a shared balance store.
// Build option ATM_MIN_BALANCE_EN: withdraw/transfer must leave at least MIN_BAL in the source account.
module atm_bank_arbiter #(
  parameter int NUM_TERM = 4,
  parameter int ACCT_AW  = 4,
  parameter int BAL_W    = 10,
  parameter int MIN_BAL  = 500
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_TERM-1:0]         req,
  input  logic [NUM_TERM*3-1:0]       term_op,
  input  logic [NUM_TERM*ACCT_AW-1:0] term_src,
  input  logic [NUM_TERM*ACCT_AW-1:0] term_dst,
  input  logic [NUM_TERM*BAL_W-1:0]   term_amount,
  output logic [NUM_TERM-1:0]         grant,
  output logic                        done,
  output logic [1:0]                  resp_status,
  output logic [BAL_W-1:0]            resp_balance,
  output logic [ACCT_AW-1:0]          mem_addr,
  output logic                        mem_we,
  output logic [BAL_W-1:0]            mem_wdata,
  input  logic [BAL_W-1:0]            mem_rdata,
  output logic [2:0]                  o_dbg_state
);

  // Handshake: a terminal holds req until its done pulse; grant is one-hot from LATCH
  // through RESP, done pulses once in RESP, and at least one IDLE cycle separates grants.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_RD_SRC = 3'd2,
    S_RD_DST = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_SRC = 3'd5,
    S_WR_DST = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  localparam int TW = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
  localparam logic [TW-1:0]    LAST_TERM = TW'(NUM_TERM - 1);
  localparam logic [2:0]       OP_BAL    = 3'b001;
  localparam logic [2:0]       OP_XFER   = 3'b011;
  localparam logic [BAL_W-1:0] FLOOR     = BAL_W'(MIN_BAL);
`ifdef ATM_MIN_BALANCE_EN
  localparam logic FLOOR_EN = 1'b1;
`else
  localparam logic FLOOR_EN = 1'b0;
`endif

  state_t             r_state;
  logic [TW-1:0]      r_ptr;
  logic [TW-1:0]      r_win;
  logic [2:0]         r_op;
  logic [ACCT_AW-1:0] r_src;
  logic [ACCT_AW-1:0] r_dst;
  logic [BAL_W-1:0]   r_amt;
  logic [BAL_W-1:0]   r_src_bal;
  logic [BAL_W-1:0]   r_dst_bal;

  logic               w_found;
  logic [TW-1:0]      w_win;
  logic [TW-1:0]      w_idx;
  logic [BAL_W:0]     w_rem;
  logic [BAL_W:0]     w_sum;
  logic               w_insuff;
  logic               w_ovf;
  logic               w_bad;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = r_ptr;
    for (int k = 0; k < NUM_TERM; k++) begin
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = (w_idx == LAST_TERM) ? '0 : w_idx + 1'b1;
    end
  end

  // One extra bit catches the borrow (insufficient) and the carry (destination overflow).
  assign w_rem    = {1'b0, r_src_bal} - {1'b0, r_amt};
  assign w_sum    = {1'b0, r_dst_bal} + {1'b0, r_amt};
  assign w_insuff = w_rem[BAL_W] | (FLOOR_EN & (w_rem[BAL_W-1:0] < FLOOR));
  assign w_ovf    = w_sum[BAL_W];
  assign w_bad    = (r_op == 3'b000) | r_op[2] | ((r_op == OP_XFER) && (r_src == r_dst));

  assign o_dbg_state = r_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_win        <= '0;
      r_op         <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_amt        <= '0;
      r_src_bal    <= '0;
      r_dst_bal    <= '0;
      grant        <= '0;
      done         <= 1'b0;
      resp_status  <= 2'b00;
      resp_balance <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_LATCH;
            r_win    <= w_win;
            grant    <= NUM_TERM'(1) << w_win;
            r_op     <= term_op[w_win*3 +: 3];
            r_src    <= term_src[w_win*ACCT_AW +: ACCT_AW];
            r_dst    <= term_dst[w_win*ACCT_AW +: ACCT_AW];
            r_amt    <= term_amount[w_win*BAL_W +: BAL_W];
            mem_addr <= term_src[w_win*ACCT_AW +: ACCT_AW];
          end
        end
        S_LATCH: begin
          if (w_bad) begin
            r_state      <= S_RESP;
            done         <= 1'b1;
            resp_status  <= 2'b11;
            resp_balance <= '0;
          end else begin
            r_state <= S_RD_SRC;
            // Source read is already in flight; a transfer queues the destination read next.
            if (r_op == OP_XFER) mem_addr <= r_dst;
          end
        end
        S_RD_SRC: begin
          r_src_bal <= mem_rdata;
          if (r_op == OP_BAL) begin
            r_state      <= S_RESP;
            done         <= 1'b1;
            resp_status  <= 2'b00;
            resp_balance <= mem_rdata;
          end else if (r_op == OP_XFER) begin
            r_state <= S_RD_DST;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_RD_DST: begin
          r_dst_bal <= mem_rdata;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (w_insuff) begin
            r_state      <= S_RESP;
            done         <= 1'b1;
            resp_status  <= 2'b01;
            resp_balance <= r_src_bal;
          end else if ((r_op == OP_XFER) && w_ovf) begin
            r_state      <= S_RESP;
            done         <= 1'b1;
            resp_status  <= 2'b10;
            resp_balance <= r_src_bal;
          end else begin
            r_state   <= S_WR_SRC;
            mem_we    <= 1'b1;
            mem_addr  <= r_src;
            mem_wdata <= w_rem[BAL_W-1:0];
          end
        end
        S_WR_SRC: begin
          if (r_op == OP_XFER) begin
            r_state   <= S_WR_DST;
            mem_we    <= 1'b1;
            mem_addr  <= r_dst;
            mem_wdata <= w_sum[BAL_W-1:0];
          end else begin
            r_state      <= S_RESP;
            done         <= 1'b1;
            resp_status  <= 2'b00;
            resp_balance <= w_rem[BAL_W-1:0];
          end
        end
        S_WR_DST: begin
          r_state      <= S_RESP;
          done         <= 1'b1;
          resp_status  <= 2'b00;
          resp_balance <= w_rem[BAL_W-1:0];
        end
        S_RESP: begin
          r_state <= S_IDLE;
          grant   <= '0;
          r_ptr   <= (r_win == LAST_TERM) ? '0 : r_win + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_bank_arbiter.sv
// Directed bench for atm_bank_arbiter: RAM model, reference model feeding a scoreboard, immediate-assertion checks.
module tb_atm_bank_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req;
  logic [11:0] term_op;
  logic [15:0] term_src;
  logic [15:0] term_dst;
  logic [39:0] term_amount;
  logic [3:0]  grant;
  logic        done;
  logic [1:0]  resp_status;
  logic [9:0]  resp_balance;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [9:0]  mem_wdata;
  logic [9:0]  mem_rdata;
  logic [2:0]  o_dbg_state;

  atm_bank_arbiter #(.NUM_TERM(4), .ACCT_AW(4), .BAL_W(10), .MIN_BAL(500)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .term_op(term_op),
    .term_src(term_src), .term_dst(term_dst), .term_amount(term_amount),
    .grant(grant), .done(done), .resp_status(resp_status), .resp_balance(resp_balance),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset / store model ----------------
  always #5 clock = ~clock;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [9:0]  ram [16] = '{default: 10'd0};
  logic        pl_we = 1'b0;
  logic [3:0]  pl_addr = 4'd0;
  logic [9:0]  pl_data = 10'd0;
  int          mdl [16] = '{default: 0};

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pl_we) ram[pl_addr] <= pl_data;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q [$];  // {check_balance, status, balance, done latency}
  logic [17:0] wexp_q [$]; // {cycle offset from grant, addr, data}
  logic [45:0] obs_q [$];  // {cycle, addr, data}

  always @(negedge clock) begin
    if (reset_n && mem_we === 1'b1) obs_q.push_back({32'(cyc), mem_addr, mem_wdata});
  end

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [3:0] a, input int v);
    @(negedge clock);
    pl_we = 1'b1; pl_addr = a; pl_data = 10'(v);
    @(negedge clock);
    pl_we = 1'b0;
    mdl[a] = v;
  endtask

  task automatic drive(input int t, input logic [2:0] op, input logic [3:0] s,
                       input logic [3:0] d, input logic [9:0] a);
    term_op[t*3 +: 3]      = op;
    term_src[t*4 +: 4]     = s;
    term_dst[t*4 +: 4]     = d;
    term_amount[t*10 +: 10] = a;
    req[t] = 1'b1;
  endtask

  task automatic model_push(input logic [2:0] op, input logic [3:0] s,
                            input logic [3:0] d, input logic [9:0] a);
    int sb, db, rem, bal, lat;
    bit ins, chk;
    logic [1:0] st;
    sb  = mdl[s];
    db  = mdl[d];
    rem = sb - int'(a);
    ins = (rem < 0);
`ifdef ATM_MIN_BALANCE_EN
    if (rem < 500) ins = 1'b1;
`endif
    chk = 1'b1;
    bal = sb;
    st  = 2'd0;
    lat = 0;
    if (op == 3'd0 || op[2] || (op == 3'd3 && s == d)) begin
      st = 2'd3; lat = 1; chk = 1'b0; bal = 0;
    end else if (op == 3'd1) begin
      st = 2'd0; lat = 2;
    end else if (op == 3'd2) begin
      if (ins) begin
        st = 2'd1; lat = 3;
      end else begin
        st = 2'd0; lat = 4; bal = rem;
        wexp_q.push_back({4'd3, s, 10'(rem)});
        mdl[s] = rem;
      end
    end else begin
      if (ins) begin
        st = 2'd1; lat = 4;
      end else if (db + int'(a) > 1023) begin
        st = 2'd2; lat = 4;
      end else begin
        st = 2'd0; lat = 6; bal = rem;
        wexp_q.push_back({4'd4, s, 10'(rem)});
        wexp_q.push_back({4'd5, d, 10'(db + int'(a))});
        mdl[s] = rem;
        mdl[d] = db + int'(a);
      end
    end
    exp_q.push_back({chk, st, 10'(bal), 4'(lat)});
  endtask

  task automatic issue(input int t, input logic [2:0] op, input logic [3:0] s,
                       input logic [3:0] d, input logic [9:0] a);
    drive(t, op, s, d, a);
    model_push(op, s, d, a);
  endtask

  task automatic run_txn(input int t, input bit hold, input bit scramble);
    int n, g, nw;
    logic [16:0] e;
    logic [17:0] we;
    logic [45:0] ow;
    n = 0;
    while (grant === 4'd0 && n < 20) begin @(negedge clock); n++; end
    check("grant", 32'(grant), 32'(1) << t);
    g = cyc;
    if (scramble) begin
      term_op[t*3 +: 3]       = 3'($urandom_range(0, 7));
      term_src[t*4 +: 4]      = 4'($urandom_range(0, 15));
      term_dst[t*4 +: 4]      = 4'($urandom_range(0, 15));
      term_amount[t*10 +: 10] = 10'($urandom_range(0, 1023));
      req[t] = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    e = exp_q.pop_front();
    check("done_latency", 32'(cyc - g), 32'(e[3:0]));
    check("grant_at_done", 32'(grant), 32'(1) << t);
    check("status", 32'(resp_status), 32'(e[15:14]));
    if (e[16]) check("balance", 32'(resp_balance), 32'(e[13:4]));
    check("write_count", 32'(obs_q.size()), 32'(wexp_q.size()));
    nw = (obs_q.size() < wexp_q.size()) ? obs_q.size() : wexp_q.size();
    for (int i = 0; i < nw; i++) begin
      we = wexp_q[i];
      ow = obs_q[i];
      check("write_offset", 32'(int'(ow[45:14]) - g), 32'(we[17:14]));
      check("write_addr", 32'(ow[13:10]), 32'(we[13:10]));
      check("write_data", 32'(ow[9:0]), 32'(we[9:0]));
    end
    obs_q.delete();
    wexp_q.delete();
    if (!hold) begin
      req[t] = 1'b0;
      @(negedge clock);
      check("grant_idle", 32'(grant), 32'd0);
    end
  endtask

  task automatic check_cleared(input string pfx);
    check({pfx, "_grant"}, 32'(grant), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_status"}, 32'(resp_status), 32'd0);
    check({pfx, "_balance"}, 32'(resp_balance), 32'd0);
    check({pfx, "_addr"}, 32'(mem_addr), 32'd0);
    check({pfx, "_we"}, 32'(mem_we), 32'd0);
    check({pfx, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({pfx, "_state"}, 32'(o_dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    req = '0; term_op = '0; term_src = '0; term_dst = '0; term_amount = '0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset_n = 1'b1;
    preload(4'd0, 500); preload(4'd1, 500); preload(4'd2, 500);
    preload(4'd3, 800); preload(4'd4, 550); preload(4'd5, 1000);

    issue(0, 3'b001, 4'd2, 4'd0, 10'd0);    run_txn(0, 0, 0); // balance 500
    issue(0, 3'b010, 4'd1, 4'd0, 10'd120);  run_txn(0, 0, 0); // withdraw -> 380
    issue(0, 3'b010, 4'd1, 4'd0, 10'd600);  run_txn(0, 0, 0); // insufficient
    issue(0, 3'b011, 4'd0, 4'd3, 10'd300);  run_txn(0, 0, 0); // dst overflow
    preload(4'd3, 100);
    issue(0, 3'b011, 4'd0, 4'd3, 10'd200);  run_txn(0, 0, 0); // transfer pass
    issue(0, 3'b010, 4'd4, 4'd0, 10'd100);  run_txn(0, 0, 0); // 550 - 100
    issue(1, 3'b000, 4'd2, 4'd0, 10'd5);    run_txn(1, 0, 0); // bad op 000
    issue(2, 3'b100, 4'd2, 4'd0, 10'd5);    run_txn(2, 0, 0); // bad op 1xx
    issue(3, 3'b011, 4'd5, 4'd5, 10'd10);   run_txn(3, 0, 0); // src == dst
    issue(0, 3'b010, 4'd5, 4'd0, 10'd0);    run_txn(0, 0, 0); // amount 0
    issue(1, 3'b011, 4'd2, 4'd5, 10'd100);  run_txn(1, 0, 0); // dst overflow
    issue(2, 3'b010, 4'd2, 4'd0, 10'd50);   run_txn(2, 0, 1); // inputs change, req drops
    preload(4'd7, 923);
    issue(3, 3'b011, 4'd0, 4'd7, 10'd100);  run_txn(3, 0, 0); // dst lands on 1023
    issue(0, 3'b010, 4'd7, 4'd0, 10'd1023); run_txn(0, 0, 0); // full withdraw

    // Reset in the middle of the destination write.
    preload(4'd0, 900);
    drive(2, 3'b011, 4'd0, 4'd6, 10'd100);
    n = 0;
    while (o_dbg_state !== 3'd6 && n < 30) begin @(negedge clock); n++; end
    check("reach_wr_dst", 32'(o_dbg_state), 32'd6);
    reset_n = 1'b0;
    req = '0;
    #1;
    check_cleared("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;
    obs_q.delete();
    wexp_q.delete();
    mdl[0] = 800;
    @(negedge clock);
    check("post_reset_state", 32'(o_dbg_state), 32'd0);

    // Round-robin with all four terminals holding req.
    drive(0, 3'b001, 4'd0, 4'd0, 10'd0);
    drive(1, 3'b001, 4'd1, 4'd0, 10'd0);
    drive(2, 3'b001, 4'd2, 4'd0, 10'd0);
    drive(3, 3'b001, 4'd5, 4'd0, 10'd0);
    model_push(3'b001, 4'd0, 4'd0, 10'd0);
    model_push(3'b001, 4'd1, 4'd0, 10'd0);
    model_push(3'b001, 4'd2, 4'd0, 10'd0);
    model_push(3'b001, 4'd5, 4'd0, 10'd0);
    model_push(3'b001, 4'd0, 4'd0, 10'd0);
    for (int i = 0; i < 5; i++) begin
      run_txn(i % 4, 1, 0);
      if (i == 4) req = '0;
      @(negedge clock);
      check("rr_idle_gap", 32'(grant), 32'd0);
    end
    repeat (4) @(negedge clock);
    check("quiet_grant", 32'(grant), 32'd0);
    check("quiet_state", 32'(o_dbg_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/atm_bank_arbiter.md
Name: atm_bank_arbiter

Overview:
- Shares one account-balance store between NUM_TERM ATM terminals.
- Arbitrates terminal requests round-robin and latches the winner's operation.
- Sequences the store's single read/write port through read-check-write steps for balance, withdraw and transfer.
- Returns a status code and the resulting balance to the granted terminal. Sits between the terminal front-ends and the shared balance RAM.

Parameters:
- NUM_TERM, 4, number of requesting terminals (2..8)
- ACCT_AW, 4, account index width (16 accounts)
- BAL_W, 10, balance width; balances are unsigned, max 2^BAL_W-1
- MIN_BAL, 500, floor balance; used only with ATM_MIN_BALANCE_EN

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_TERM  per-terminal request; held high until that terminal's done
- term_op  in  NUM_TERM*3  per-terminal op: 001 balance, 010 withdraw, 011 transfer
- term_src  in  NUM_TERM*ACCT_AW  per-terminal source account
- term_dst  in  NUM_TERM*ACCT_AW  per-terminal destination account (transfer only)
- term_amount  in  NUM_TERM*BAL_W  per-terminal amount
- grant  out  NUM_TERM  one-hot grant
- done  out  1  one-cycle completion pulse to the granted terminal
- resp_status  out  2  00 OK, 01 insufficient, 10 destination overflow, 11 bad request
- resp_balance  out  BAL_W  source balance after the op; held until next done
- mem_addr  out  ACCT_AW  store address
- mem_we  out  1  store write enable
- mem_wdata  out  BAL_W  store write data
- mem_rdata  in  BAL_W  store read data, valid one cycle after mem_addr (registered read)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- States: IDLE, LATCH, RD_SRC, RD_DST, EXEC, WR_SRC, WR_DST, RESP.
- IDLE, on any req bit:
  - Pick the first requester at or after the pointer, wrapping.
  - Next cycle G = LATCH: grant bit asserted; op/src/dst/amount captured; mem_addr=src.
- grant stays asserted from LATCH through RESP inclusive and drops in the following IDLE cycle. At least one IDLE cycle between transactions.
- Input changes after LATCH are ignored.
- Op 000 or 1xx, or transfer with src==dst: LATCH -> RESP at G+1, status 11, no write.
- Balance:
  - RD_SRC at G+1 captures mem_rdata.
  - RESP at G+2: status 00, resp_balance = captured value.
- Withdraw:
  - RD_SRC G+1, then EXEC G+2.
  - If amount <= src: WR_SRC G+3 writes src-amount, then RESP G+4 with status 00.
  - Otherwise RESP G+3: status 01, resp_balance = unchanged src.
- Transfer:
  - RD_SRC G+1 captures src; mem_addr=dst. RD_DST G+2 captures dst. EXEC G+3.
  - Check order: insufficient (01) first, then dst+amount > 2^BAL_W-1 (10), computed at BAL_W+1 bits.
  - Pass: WR_SRC G+4, WR_DST G+5, RESP G+6 status 00.
  - Fail: RESP G+4, no write.
- mem_we high only in WR_SRC/WR_DST, exactly one cycle each. mem_addr holds the target account in those states.
- RESP:
  - done=1 for one cycle; resp_status/resp_balance update in the same cycle.
  - Pointer moves to winner+1 mod NUM_TERM.
- Requester dropping req mid-transaction: transaction still completes and writes; done is still pulsed.
- Reset mid-transaction aborts immediately. A write already performed stays; a pending WR_DST is lost. The bench must not rely on atomicity across reset.
- Amount 0 is legal: status 00, writes the unchanged value.

Optional Feature:
- ATM_MIN_BALANCE_EN defined: withdraw/transfer pass only if src - amount >= MIN_BAL; otherwise status 01.
- Undefined: the only requirement is amount <= src.
- The balance op is unaffected either way.

Test Plan:
- Balance: req[0], op 001, src 2, RAM[2]=500 -> grant=0001 at G, done at G+2, status 00, balance 500, mem_we never high.
- Withdraw 120 from RAM[1]=500 -> one write of 380 to addr 1 at G+3, done G+4, status 00, balance 380. Amount 600 -> done G+3, status 01, no write.
- Transfer 300 from src 0 (500) to dst 3 (800) -> status 10, no writes.
- Transfer 200 from src 0 (500) to dst 3 (100) -> writes 300 @0 (G+4), 300 @3 (G+5), done G+6.
- Round-robin: req=1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order, each separated by one IDLE cycle.
- Reset_n low during WR_DST of a transfer -> all outputs 0 immediately; after release, IDLE; next grant goes to terminal 0.
- ATM_MIN_BALANCE_EN: withdraw 100 from 550 -> status 01. Without the macro -> status 00, balance 450.
